// File: rtl/muldiv_iter.sv
// muldiv_iter
//
// Iterative multiply/divide unit covering the eight RV32M funct3 operations
// for an XLEN-bit datapath. It sits beside the single-cycle ALU. The core
// stalls while busy is high and captures y when done pulses.
//
// Multiplies use an unsigned shift-add over operand magnitudes. Divides use
// restoring division on operand magnitudes. In both cases the sign is applied
// when the result is written out. Divide-by-zero and signed overflow skip the
// iterations entirely and finish one cycle after accept.
//
// Ports
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   start  : operation request, sampled only while idle (IDLE or FIN)
//   kill   : abort the operation in flight, or block a same-cycle start
//   op     : funct3 select
//            000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//            100 DIV, 101 DIVU, 110 REM,    111 REMU
//   a, b   : rs1 / rs2 operands
//   busy   : iterations in progress
//   done   : one-cycle pulse, y and dz valid
//   y      : result, held until the next completion or reset
//   dz     : divide by zero flag, updated together with y

module muldiv_iter #(
    parameter int XLEN = 32,
    parameter int CNTW = $clog2(XLEN + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] y,
    output logic            dz
);

    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIN
    } state_t;

    state_t state_q, state_d;

    logic [CNTW-1:0] cnt_q;
    logic [2:0]      op_q;
    logic            sa_q, sb_q;
    logic [XLEN-1:0] acc_hi_q;
    logic [XLEN-1:0] acc_lo_q;
    logic [XLEN-1:0] opnd_q;
    logic [XLEN-1:0] y_q;
    logic            dz_q;

    logic            accept;
    logic            last_iter;

    logic            sa, sb;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            b_zero, ovf, fast;
    logic [XLEN-1:0] fast_y;

    logic [XLEN:0]     mul_addend;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_fits;
    logic [XLEN-1:0]   div_sub;
    logic [XLEN-1:0]   hi_nx, lo_nx;
    logic [2*XLEN-1:0] product, prod_s;
    logic [XLEN-1:0]   quot_s, rem_s;
    logic [XLEN-1:0]   calc_res;

    // Operand decode at accept time. Signed operands are replaced by their
    // magnitude. The most negative value wraps onto itself and is then treated
    // as the unsigned value 2^(XLEN-1), which is exactly the magnitude the
    // iterations need. Divide-by-zero and MIN / -1 are recognised here so
    // they can bypass the iterations.
    always_comb begin
        sa     = ((op == OP_DIV) || (op == OP_REM) || (op == OP_MULH) || (op == OP_MULHSU))
                 && a[XLEN-1];
        sb     = ((op == OP_DIV) || (op == OP_REM) || (op == OP_MULH)) && b[XLEN-1];
        mag_a  = sa ? -a : a;
        mag_b  = sb ? -b : b;
        b_zero = op[2] && (b == '0);
        ovf    = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_VAL) && (b == '1);
        fast   = b_zero || ovf;
        fast_y = '0;
        if (b_zero) begin
            fast_y = op[1] ? a : '1;
        end else if (ovf) begin
            fast_y = op[1] ? '0 : MIN_VAL;
        end
    end

    // One iteration step for both algorithms, sharing the same registers.
    // Multiply: acc_hi holds the partial product, acc_lo the multiplier.
    // Each step adds the multiplicand when the low multiplier bit is set, then
    // shifts {carry, acc_hi, acc_lo} right by one.
    // Divide: acc_hi is the partial remainder, acc_lo the dividend. Each step
    // shifts the next dividend bit into the remainder and subtracts the
    // divisor if it fits. The quotient bit enters acc_lo from the right.
    // The signed result is also formed here, so the last step can write y
    // in the same edge that moves the FSM to FIN.
    always_comb begin
        mul_addend = acc_lo_q[0] ? {1'b0, opnd_q} : '0;
        mul_sum    = {1'b0, acc_hi_q} + mul_addend;
        div_shift  = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_fits   = (div_shift >= {1'b0, opnd_q});
        div_sub    = XLEN'(div_shift - {1'b0, opnd_q});
        if (op_q[2]) begin
            hi_nx = div_fits ? div_sub : div_shift[XLEN-1:0];
            lo_nx = {acc_lo_q[XLEN-2:0], div_fits};
        end else begin
            hi_nx = mul_sum[XLEN:1];
            lo_nx = {mul_sum[0], acc_lo_q[XLEN-1:1]};
        end
        product = {hi_nx, lo_nx};
        prod_s  = (sa_q ^ sb_q) ? -product : product;
        quot_s  = (sa_q ^ sb_q) ? -lo_nx : lo_nx;
        rem_s   = sa_q ? -hi_nx : hi_nx;
        if (op_q[2]) begin
            calc_res = op_q[1] ? rem_s : quot_s;
        end else begin
            calc_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and status outputs. FIN behaves like IDLE for accepting a new
    // start, which gives back-to-back operation. kill always wins over start
    // and over completion. The counter holds the remaining steps, so the last
    // step is taken when it reads 1 and it reaches 0 on the way into FIN.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_iter = (cnt_q == CNTW'(1));
        busy      = (state_q == ST_CALC);
        done      = (state_q == ST_FIN);
        case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (start && !kill) begin
                    accept  = 1'b1;
                    state_d = fast ? ST_FIN : ST_CALC;
                end
            end
            ST_CALC: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else if (last_iter) begin
                    state_d = ST_FIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath registers. On accept the operation, sign flags and operand
    // magnitudes are captured, so later changes on a/b/op are ignored. A
    // fast-path accept writes y/dz right away. Otherwise y/dz are written
    // only by the final iteration. A killed operation leaves y/dz untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            y_q      <= '0;
            dz_q     <= 1'b0;
        end else if (accept) begin
            op_q     <= op;
            sa_q     <= sa;
            sb_q     <= sb;
            acc_hi_q <= '0;
            acc_lo_q <= op[2] ? mag_a : mag_b;
            opnd_q   <= op[2] ? mag_b : mag_a;
            if (fast) begin
                cnt_q <= '0;
                y_q   <= fast_y;
                dz_q  <= b_zero;
            end else begin
                cnt_q <= CNTW'(XLEN);
            end
        end else if (state_q == ST_CALC) begin
            if (kill) begin
                cnt_q <= '0;
            end else begin
                acc_hi_q <= hi_nx;
                acc_lo_q <= lo_nx;
                cnt_q    <= cnt_q - CNTW'(1);
                if (last_iter) begin
                    y_q  <= calc_res;
                    dz_q <= 1'b0;
                end
            end
        end
    end

    assign y  = y_q;
    assign dz = dz_q;

endmodule
